matrix_result_unloader: RTL and testbench

//  Reads the product matrix C (ROW_A x COLUMN_B, row-major) out of the multiplier's main memory once

---
 rtl/matrix_pkg.sv | 28 ++
 rtl/matrix_index_counter.sv | 46 ++++
 rtl/matrix_result_unloader.sv | 134 +++++++++++++
 tb/tb_matrix_result_unloader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix load/multiply/unload path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package matrix_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    // Unloader FSM encoding; IDLE must be zero so a cleared register means idle.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } unload_state_t;

    // Row-major element address, wrapping in ADDR_W-bit unsigned arithmetic.
    function automatic logic [ADDR_W-1:0] elem_addr(
        input logic [ADDR_W-1:0] base,
        input logic [7:0]        row,
        input logic [7:0]        col,
        input logic [ADDR_W-1:0] ncols
    );
        return base + ADDR_W'(row) * ncols + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column walker over a ROWS x COLS matrix in row-major order.
// Latency: counters update on the edge where advance/clear is sampled; last is combinational.
// Backpressure: none; the owner only pulses advance once per accepted element.
//
// Ports:
//   clk, reset      clock, async active-low reset
//   clear           return to (0,0); wins over advance
//   advance         step to the next element (col first, then row)
//   row, col        current element index
//   last            current element is (ROWS-1, COLS-1)
module matrix_index_counter #(
    parameter int ROWS = 2,
    parameter int COLS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic       last
);

    localparam logic [7:0] ROW_MAX = 8'(ROWS - 1);
    localparam logic [7:0] COL_MAX = 8'(COLS - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= 8'd0;
            col <= 8'd0;
        end else if (clear) begin
            row <= 8'd0;
            col <= 8'd0;
        end else if (advance) begin
            if (col == COL_MAX) begin
                col <= 8'd0;
                row <= (row == ROW_MAX) ? 8'd0 : row + 8'd1;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

    assign last = (row == ROW_MAX) && (col == COL_MAX);

endmodule

// File: rtl/matrix_result_unloader.sv
// Drains product matrix C from the shared memory and streams it out element by element.
// Latency: 3 cycles per element (read, data return, hold); full matrix in 3*ROW_A*COLUMN_B + 1 cycles.
// Backpressure: out_ready low freezes the held element; no further memory reads until it is accepted.
//
// Ports:
//   clk, reset               clock, async active-low reset
//   start                    one-cycle unload request, only honoured in IDLE
//   mem_rd_en/mem_addr       read request to the shared memory port
//   mem_data                 read data, one cycle after mem_rd_en
//   out_data/row/col/last    current element and its position
//   out_valid/out_ready      element handshake
//   busy                     unload in progress
//   unload_done              one-cycle pulse after the final element is accepted
module matrix_result_unloader #(
    parameter int ROW_A    = 2,
    parameter int COLUMN_B = 2,
    parameter int DATA_W   = matrix_pkg::DATA_W,
    parameter int ADDR_W   = matrix_pkg::ADDR_W,
    parameter int BASE_C   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_row,
    output logic [7:0]        out_col,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              unload_done
);

    import matrix_pkg::*;

    localparam int PKG_AW = matrix_pkg::ADDR_W;

    unload_state_t state, state_nxt;

    logic       cnt_clear;
    logic       cnt_adv;
    logic [7:0] cnt_row;
    logic [7:0] cnt_col;
    logic       cnt_last;

    matrix_index_counter #(
        .ROWS (ROW_A),
        .COLS (COLUMN_B)
    ) u_index (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .advance (cnt_adv),
        .row     (cnt_row),
        .col     (cnt_col),
        .last    (cnt_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_rd_en   = 1'b0;
        mem_addr    = '0;
        cnt_clear   = 1'b0;
        cnt_adv     = 1'b0;
        busy        = 1'b1;
        unload_done = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    cnt_clear = 1'b1;
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = ADDR_W'(elem_addr(PKG_AW'(BASE_C), cnt_row, cnt_col,
                                              PKG_AW'(COLUMN_B)));
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (out_last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_adv   = 1'b1;
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                unload_done = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output element registers: loaded as the read data returns, held until accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_row   <= 8'd0;
            out_col   <= 8'd0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (state == ST_WAIT) begin
            out_data  <= mem_data;
            out_row   <= cnt_row;
            out_col   <= cnt_col;
            out_last  <= cnt_last;
            out_valid <= 1'b1;
        end else if (state == ST_HOLD && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_matrix_result_unloader.sv
module tb_matrix_result_unloader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  start;
    logic [2:0]  out_ready;
    wire  [2:0]  mem_rd_en;
    wire  [2:0]  out_last;
    wire  [2:0]  out_valid;
    wire  [2:0]  busy;
    wire  [2:0]  unload_done;
    wire  [9:0]  mem_addr [3];
    wire  [31:0] out_data [3];
    wire  [7:0]  out_row  [3];
    wire  [7:0]  out_col  [3];
    logic [31:0] mem_q    [3];
    logic [31:0] mem      [3][1024];

    int base_of [3] = '{8, 8, 100};
    int rd_cnt  [3];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] d;
        int          r;
        int          c;
        bit          last;
    } elem_t;

    // Instance 0: 2x2 at 8; instance 1: 1x1 at 8; instance 2: 3x4 at 100.
    matrix_result_unloader #(.ROW_A(2), .COLUMN_B(2), .BASE_C(8)) dut0 (
        .clk(clk), .reset(rst_n), .start(start[0]),
        .mem_rd_en(mem_rd_en[0]), .mem_addr(mem_addr[0]), .mem_data(mem_q[0]),
        .out_data(out_data[0]), .out_row(out_row[0]), .out_col(out_col[0]),
        .out_last(out_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .busy(busy[0]), .unload_done(unload_done[0])
    );

    matrix_result_unloader #(.ROW_A(1), .COLUMN_B(1), .BASE_C(8)) dut1 (
        .clk(clk), .reset(rst_n), .start(start[1]),
        .mem_rd_en(mem_rd_en[1]), .mem_addr(mem_addr[1]), .mem_data(mem_q[1]),
        .out_data(out_data[1]), .out_row(out_row[1]), .out_col(out_col[1]),
        .out_last(out_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .busy(busy[1]), .unload_done(unload_done[1])
    );

    matrix_result_unloader #(.ROW_A(3), .COLUMN_B(4), .BASE_C(100)) dut2 (
        .clk(clk), .reset(rst_n), .start(start[2]),
        .mem_rd_en(mem_rd_en[2]), .mem_addr(mem_addr[2]), .mem_data(mem_q[2]),
        .out_data(out_data[2]), .out_row(out_row[2]), .out_col(out_col[2]),
        .out_last(out_last[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .busy(busy[2]), .unload_done(unload_done[2])
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Memory model: one-cycle read latency.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_rd_en[k] === 1'b1) mem_q[k] <= mem[k][mem_addr[k]];
        end
    end

    // Reads must walk the matrix in row-major order: the i-th read is base + i.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n === 1'b1 && mem_rd_en[k] === 1'b1) begin
                chk("mem_addr", 32'(mem_addr[k]), 32'(base_of[k] + rd_cnt[k]));
                rd_cnt[k]++;
            end
        end
    end

    task automatic chk_all_zero(input int k, input string tag);
        chk({tag, "_valid"}, 32'(out_valid[k]), 32'd0);
        chk({tag, "_data"},  out_data[k], 32'd0);
        chk({tag, "_row"},   32'(out_row[k]), 32'd0);
        chk({tag, "_col"},   32'(out_col[k]), 32'd0);
        chk({tag, "_last"},  32'(out_last[k]), 32'd0);
        chk({tag, "_busy"},  32'(busy[k]), 32'd0);
        chk({tag, "_done"},  32'(unload_done[k]), 32'd0);
        chk({tag, "_rd_en"}, 32'(mem_rd_en[k]), 32'd0);
        chk({tag, "_addr"},  32'(mem_addr[k]), 32'd0);
    endtask

    // One unload on instance k. Observation n counts negedges after the edge that samples start.
    // Model: an element is presented 3 cycles after start / after the previous acceptance,
    // unload_done follows the final acceptance by one cycle, then idle.
    task automatic run_unload(input int k, input int rows, input int cols, input int stall_pct,
                              input int fixed_stall, input bit repulse, input int abort_elem,
                              output int done_n);
        elem_t q[$];
        elem_t e;
        int    n, valid_at, done_at, accepted, hold_cnt;
        bit    rdy, finished, model_valid;

        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                e.d    = mem[k][base_of[k] + r * cols + c];
                e.r    = r;
                e.c    = c;
                e.last = (r == rows - 1) && (c == cols - 1);
                q.push_back(e);
            end
        end
        rd_cnt[k] = 0;
        done_n    = -1;
        valid_at  = 3;
        done_at   = -1;
        accepted  = 0;
        hold_cnt  = 0;
        finished  = 1'b0;

        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        n = 1;
        while (!finished) begin
            if (abort_elem >= 0 && accepted == abort_elem && n == valid_at - 1) begin
                rst_n = 1'b0;
                #1;
                chk_all_zero(k, "abort");
                @(negedge clk);
                rst_n = 1'b1;
                out_ready[k] = 1'b0;
                return;
            end
            model_valid = (valid_at >= 0) && (n >= valid_at);
            chk("out_valid",   32'(out_valid[k]),   32'(model_valid));
            chk("unload_done", 32'(unload_done[k]), 32'(n == done_at));
            chk("busy",        32'(busy[k]),        32'(done_at < 0 || n <= done_at));
            rdy = ($urandom_range(99) >= 32'(stall_pct));
            if (model_valid && q.size() > 0) begin
                e = q[0];
                chk("out_data", out_data[k], e.d);
                chk("out_row",  32'(out_row[k]), 32'(e.r));
                chk("out_col",  32'(out_col[k]), 32'(e.c));
                chk("out_last", 32'(out_last[k]), 32'(e.last));
                hold_cnt++;
                if (fixed_stall > 0) rdy = (hold_cnt > fixed_stall);
                if (repulse && accepted == 1 && hold_cnt == 1) start[k] = 1'b1;
                if (rdy) begin
                    void'(q.pop_front());
                    accepted++;
                    hold_cnt = 0;
                    if (e.last) begin
                        done_at  = n + 1;
                        valid_at = -1;
                    end else begin
                        valid_at = n + 3;
                    end
                end
            end
            out_ready[k] = rdy;
            if (done_at >= 0 && n == done_at) done_n = n;
            if (done_at >= 0 && n == done_at + 1) finished = 1'b1;
            if (n > 2000) begin
                chk("timeout", 32'd1, 32'd0);
                finished = 1'b1;
            end
            if (!finished) begin
                @(negedge clk);
                start[k] = 1'b0;
                n++;
            end
        end
        chk("rd_pulses", 32'(rd_cnt[k]), 32'(rows * cols));
        chk("elems_left", 32'(q.size()), 32'd0);
        out_ready[k] = 1'b0;
    endtask

    initial begin
        int dn;
        rst_n     = 1'b0;
        start     = 3'b000;
        out_ready = 3'b000;
        for (int k = 0; k < 3; k++) begin
            rd_cnt[k] = 0;
            for (int a = 0; a < 1024; a++) mem[k][a] = 32'd0;
        end
        #22;
        for (int k = 0; k < 3; k++) chk_all_zero(k, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1) 2x2 directed, always ready: done 13 cycles after start is sampled.
        mem[0][8]  = 32'h11;
        mem[0][9]  = 32'h22;
        mem[0][10] = 32'h33;
        mem[0][11] = 32'h44;
        run_unload(0, 2, 2, 0, 0, 1'b0, -1, dn);
        chk("t1_done_cycle", 32'(dn), 32'd13);

        // 2) each element held off for 5 cycles.
        run_unload(0, 2, 2, 0, 5, 1'b0, -1, dn);
        chk("t2_done_cycle", 32'(dn), 32'd33);

        // 3) start re-pulsed while the second element is held.
        run_unload(0, 2, 2, 0, 0, 1'b1, -1, dn);
        chk("t3_done_cycle", 32'(dn), 32'd13);

        // 4) reset during the data-return cycle of the second element, then a clean restart.
        run_unload(0, 2, 2, 0, 0, 1'b0, 1, dn);
        run_unload(0, 2, 2, 0, 0, 1'b0, -1, dn);
        chk("t4_done_cycle", 32'(dn), 32'd13);

        // Random data and random backpressure on the 2x2 instance.
        for (int it = 0; it < 4; it++) begin
            for (int a = 8; a < 12; a++) mem[0][a] = $urandom;
            run_unload(0, 2, 2, 40, 0, 1'b0, -1, dn);
        end

        // 5) single element.
        mem[1][8] = 32'hDEADBEEF;
        run_unload(1, 1, 1, 0, 0, 1'b0, -1, dn);
        chk("t5_done_cycle", 32'(dn), 32'd4);
        run_unload(1, 1, 1, 50, 0, 1'b0, -1, dn);

        // 6) 3x4 at base 100.
        for (int a = 100; a < 112; a++) mem[2][a] = $urandom;
        run_unload(2, 3, 4, 0, 0, 1'b0, -1, dn);
        chk("t6_done_cycle", 32'(dn), 32'd37);
        for (int it = 0; it < 3; it++) begin
            for (int a = 100; a < 112; a++) mem[2][a] = $urandom;
            run_unload(2, 3, 4, 35, 0, 1'b0, -1, dn);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
